sys_array_ctrl: RTL and testbench

- Sequencer for the M x M output-stationary systolic matmul array.
- Accepts a serial stream of A/B element pairs and buffers one full operand set.
- Drives the skewed row/column feeds and enable/clear into the PE grid.
- Drains the M*M results as a serial valid/ready stream, row-major.

---
 rtl/sys_array_ctrl_if.sv | 24 ++
 rtl/sys_array_ctrl.sv | 151 +++++++++++++++
 tb/tb_sys_array_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_array_ctrl_if.sv
// Operand and result stream handshakes for the systolic array sequencer.
// The master modport is the stream source/sink side. The slave modport is the controller side.
interface sys_array_ctrl_if #(
    parameter int DW = 8,
    parameter int CW = 16
);
    logic          in_vld;
    logic          in_rdy;
    logic [DW-1:0] a_in;
    logic [DW-1:0] b_in;
    logic          out_vld;
    logic          out_rdy;
    logic [CW-1:0] c_out;

    modport master (
        output in_vld, a_in, b_in, out_rdy,
        input  in_rdy, out_vld, c_out
    );

    modport slave (
        input  in_vld, a_in, b_in, out_rdy,
        output in_rdy, out_vld, c_out
    );
endinterface

// File: rtl/sys_array_ctrl.sv
// Sequencer for an M x M output-stationary systolic matmul array.
// It buffers one operand set, feeds skewed rows and columns, and drains C row-major.
module sys_array_ctrl #(
    parameter int M  = 3,
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic              CLK,
    input  logic              rst,
    sys_array_ctrl_if.slave   bus,
    output logic [M*DW-1:0]   arr_a,
    output logic [M*DW-1:0]   arr_b,
    output logic              arr_en,
    output logic              arr_clr,
    input  logic [M*M*CW-1:0] arr_c,
    output logic              busy,
    output logic              done
);
    localparam int NE = M * M;
    localparam int NS = 3 * M - 2;
    localparam int RW = $clog2(M);
    localparam int IW = $clog2(NE);
    localparam int SW = $clog2(NS);

    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_CLEAR   = 2'd1;
    localparam logic [1:0] ST_COMPUTE = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    logic [1:0]    state;
    logic [RW-1:0] ld_row;
    logic [RW-1:0] ld_col;
    logic [SW-1:0] s_cnt;
    logic [IW-1:0] idx;
    logic          out_vld_q;
    logic [CW-1:0] c_q;

    logic [DW-1:0] a_buf [M][M];
    logic [DW-1:0] b_buf [M][M];

    logic          feed_on;
    logic [SW-1:0] feed_s;
    logic [M*DW-1:0] a_feed;
    logic [M*DW-1:0] b_feed;

    assign bus.in_rdy  = (state == ST_LOAD);
    assign bus.out_vld = out_vld_q;
    assign bus.c_out   = c_q;
    assign arr_en      = (state == ST_COMPUTE);
    assign arr_clr     = (state == ST_CLEAR);
    assign busy        = (state != ST_LOAD);

    // A is stored column-major and B row-major, so both buffers end up indexed [row][col].
    always_ff @(posedge CLK) begin
        if (state == ST_LOAD && bus.in_vld) begin
            a_buf[ld_row][ld_col] <= bus.a_in;
            b_buf[ld_col][ld_row] <= bus.b_in;
        end
    end

    // Feeds are computed for the step that the next cycle will run, so that arr_a/arr_b are registered.
    always_comb begin
        feed_on = 1'b0;
        feed_s  = '0;
        a_feed  = '0;
        b_feed  = '0;
        if (state == ST_CLEAR) begin
            feed_on = 1'b1;
        end else if (state == ST_COMPUTE && s_cnt != SW'(NS - 1)) begin
            feed_on = 1'b1;
            feed_s  = s_cnt + 1'b1;
        end
        if (feed_on) begin
            for (int unsigned i = 0; i < M; i++) begin
                for (int unsigned t = 0; t < M; t++) begin
                    if (feed_s == SW'(i + t)) begin
                        a_feed[i*DW +: DW] = a_buf[i][t];
                        b_feed[i*DW +: DW] = b_buf[t][i];
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state     <= ST_LOAD;
            ld_row    <= '0;
            ld_col    <= '0;
            s_cnt     <= '0;
            idx       <= '0;
            out_vld_q <= 1'b0;
            c_q       <= '0;
            arr_a     <= '0;
            arr_b     <= '0;
            done      <= 1'b0;
        end else begin
            done  <= 1'b0;
            arr_a <= a_feed;
            arr_b <= b_feed;
            case (state)
                ST_LOAD: begin
                    if (bus.in_vld) begin
                        if (ld_row == RW'(M - 1)) begin
                            ld_row <= '0;
                            if (ld_col == RW'(M - 1)) begin
                                ld_col <= '0;
                                state  <= ST_CLEAR;
                            end else begin
                                ld_col <= ld_col + 1'b1;
                            end
                        end else begin
                            ld_row <= ld_row + 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    s_cnt <= '0;
                    state <= ST_COMPUTE;
                end
                ST_COMPUTE: begin
                    if (s_cnt == SW'(NS - 1)) begin
                        // C[0][0] completed long before the last MAC, so it is safe to capture now.
                        s_cnt     <= '0;
                        idx       <= '0;
                        out_vld_q <= 1'b1;
                        c_q       <= arr_c[0 +: CW];
                        state     <= ST_DRAIN;
                    end else begin
                        s_cnt <= s_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (bus.out_rdy) begin
                        if (idx == IW'(NE - 1)) begin
                            idx       <= '0;
                            out_vld_q <= 1'b0;
                            c_q       <= '0;
                            done      <= 1'b1;
                            state     <= ST_LOAD;
                        end else begin
                            idx <= idx + 1'b1;
                            c_q <= arr_c[(int'(idx) + 1) * CW +: CW];
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_sys_array_ctrl.sv
// Directed bench for sys_array_ctrl. It uses a behavioural output-stationary PE grid.
// A result scoreboard is filled at load time and drained on each accepted beat.
module tb_sys_array_ctrl;
    localparam int M  = 3;
    localparam int DW = 8;
    localparam int CW = 16;
    localparam int NE = M * M;
    localparam int NS = 3 * M - 2;

    logic              CLK = 1'b0;
    logic              rst;
    logic [M*DW-1:0]   arr_a;
    logic [M*DW-1:0]   arr_b;
    logic              arr_en;
    logic              arr_clr;
    logic [M*M*CW-1:0] arr_c;
    logic              busy;
    logic              done;

    sys_array_ctrl_if #(.DW(DW), .CW(CW)) bus ();

    sys_array_ctrl #(.M(M), .DW(DW), .CW(CW)) dut (
        .CLK    (CLK),
        .rst    (rst),
        .bus    (bus),
        .arr_a  (arr_a),
        .arr_b  (arr_b),
        .arr_en (arr_en),
        .arr_clr(arr_clr),
        .arr_c  (arr_c),
        .busy   (busy),
        .done   (done)
    );

    always #5 CLK = ~CLK;

    // Behavioural PE grid: A flows east, B flows south, and C accumulates in place.
    logic [DW-1:0] pa  [M][M];
    logic [DW-1:0] pb  [M][M];
    logic [CW-1:0] acc [M][M];

    function automatic logic [DW-1:0] west(input int i, input int j);
        if (j == 0) return arr_a[i*DW +: DW];
        return pa[i][j-1];
    endfunction

    function automatic logic [DW-1:0] north(input int i, input int j);
        if (i == 0) return arr_b[j*DW +: DW];
        return pb[i-1][j];
    endfunction

    always @(posedge CLK or posedge rst) begin
        if (rst || arr_clr) begin
            for (int i = 0; i < M; i++)
                for (int j = 0; j < M; j++) begin
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                    acc[i][j] <= '0;
                end
        end else if (arr_en) begin
            for (int i = 0; i < M; i++)
                for (int j = 0; j < M; j++) begin
                    pa[i][j]  <= west(i, j);
                    pb[i][j]  <= north(i, j);
                    acc[i][j] <= acc[i][j] + CW'(west(i, j)) * CW'(north(i, j));
                end
        end
    end

    always_comb begin
        arr_c = '0;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++)
                arr_c[(i*M+j)*CW +: CW] = acc[i][j];
    end

    int checks = 0;
    int errors = 0;
    int mat_a [M][M];
    int mat_b [M][M];
    logic [CW-1:0] sb_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [M*DW-1:0] exp_feed(input bit is_b, input int s);
        logic [M*DW-1:0] f = '0;
        for (int i = 0; i < M; i++)
            if (s - i >= 0 && s - i < M)
                f[i*DW +: DW] = is_b ? DW'(mat_b[s-i][i]) : DW'(mat_a[i][s-i]);
        return f;
    endfunction

    task automatic set_identity();
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++) begin
                mat_a[i][j] = (i == j) ? 1 : 0;
                mat_b[i][j] = (i == j) ? 1 : 0;
            end
    endtask

    task automatic set_general();
        mat_a = '{'{1, 1, 0}, '{0, 1, 0}, '{0, 1, 1}};
        mat_b = '{'{1, 0, 0}, '{0, 2, 0}, '{2, 0, 1}};
    endtask

    // Called at posedge+1. It returns at posedge+1 of the CLEAR cycle.
    task automatic load_ops(input int gap);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++) begin
                int sum = 0;
                for (int k = 0; k < M; k++) sum += mat_a[i][k] * mat_b[k][j];
                sb_q.push_back(CW'(sum));
            end
        for (int k = 0; k < NE; k++) begin
            for (int g = 0; g < ((k > 0) ? gap : 0); g++) begin
                bus.in_vld = 1'b0;
                bus.a_in   = 8'hEE;
                bus.b_in   = 8'hDD;
                @(negedge CLK);
                chk("gap_in_rdy", bus.in_rdy, 1);
                chk("gap_busy", busy, 0);
                @(posedge CLK); #1;
            end
            bus.in_vld = 1'b1;
            bus.a_in   = DW'(mat_a[k%M][k/M]);
            bus.b_in   = DW'(mat_b[k/M][k%M]);
            @(negedge CLK);
            chk("load_in_rdy", bus.in_rdy, 1);
            @(posedge CLK); #1;
        end
        // Junk beats offered outside LOAD must be ignored.
        bus.in_vld = 1'b1;
        bus.a_in   = 8'h55;
        bus.b_in   = 8'hAA;
    endtask

    // Checks CLEAR and the first n compute steps. For a full run, it also checks the first DRAIN cycle.
    task automatic check_compute(input int n);
        @(negedge CLK);
        chk("clear_clr", arr_clr, 1);
        chk("clear_en", arr_en, 0);
        chk("clear_in_rdy", bus.in_rdy, 0);
        chk("clear_busy", busy, 1);
        chk("clear_feed_a", arr_a, 0);
        for (int s = 0; s < n; s++) begin
            @(posedge CLK); #1;
            @(negedge CLK);
            chk($sformatf("comp_en_s%0d", s), arr_en, 1);
            chk($sformatf("comp_clr_s%0d", s), arr_clr, 0);
            chk($sformatf("comp_vld_s%0d", s), bus.out_vld, 0);
            chk($sformatf("comp_in_rdy_s%0d", s), bus.in_rdy, 0);
            chk($sformatf("feed_a_s%0d", s), arr_a, exp_feed(1'b0, s));
            chk($sformatf("feed_b_s%0d", s), arr_b, exp_feed(1'b1, s));
        end
        if (n >= NS) begin
            bus.in_vld = 1'b0;
            @(posedge CLK); #1;
            @(negedge CLK);
            chk("drain0_vld", bus.out_vld, 1);
            chk("drain0_en", arr_en, 0);
            chk("drain0_feed_a", arr_a, 0);
            chk("drain0_feed_b", arr_b, 0);
        end
    endtask

    // Called at the negedge of the first DRAIN cycle. It returns at posedge+1.
    task automatic drain(input int stall_beat, input int stall_len);
        int beats   = 0;
        int stalled = 0;
        int guard   = 0;
        while (beats < NE && guard < 64) begin
            guard++;
            bus.out_rdy = !(beats == stall_beat && stalled < stall_len);
            if (!bus.out_rdy) stalled++;
            #1;
            chk($sformatf("drain_vld_b%0d", beats), bus.out_vld, 1);
            chk($sformatf("drain_done_low_b%0d", beats), done, 0);
            if (sb_q.size() == 0) begin
                chk("scoreboard_empty", 1, 0);
            end else begin
                chk($sformatf("c_out_b%0d", beats), bus.c_out, sb_q[0]);
                if (bus.out_rdy) begin
                    void'(sb_q.pop_front());
                    beats++;
                end
            end
            @(negedge CLK);
        end
        chk("drain_beats", beats, NE);
        bus.out_rdy = 1'b1;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_in_rdy", bus.in_rdy, 1);
        chk("done_vld_low", bus.out_vld, 0);
        @(negedge CLK);
        chk("done_one_cycle", done, 0);
        @(posedge CLK); #1;
    endtask

    initial begin
        rst         = 1'b1;
        bus.in_vld  = 1'b0;
        bus.a_in    = '0;
        bus.b_in    = '0;
        bus.out_rdy = 1'b1;
        @(negedge CLK);
        chk("rst_arr_a", arr_a, 0);
        chk("rst_arr_b", arr_b, 0);
        chk("rst_en", arr_en, 0);
        chk("rst_clr", arr_clr, 0);
        chk("rst_vld", bus.out_vld, 0);
        chk("rst_c_out", bus.c_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge CLK); #1;
        rst = 1'b0;
        @(negedge CLK);
        chk("rst_rel_in_rdy", bus.in_rdy, 1);
        @(posedge CLK); #1;

        set_identity();
        load_ops(0);
        check_compute(NS);
        drain(-1, 0);

        set_general();
        load_ops(0);
        check_compute(NS);
        drain(-1, 0);

        load_ops(2);
        check_compute(NS);
        drain(-1, 0);

        load_ops(0);
        check_compute(NS);
        drain(4, 3);

        set_identity();
        load_ops(0);
        check_compute(3);
        rst = 1'b1;
        #1;
        chk("abort_in_rdy", bus.in_rdy, 1);
        chk("abort_en", arr_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_vld", bus.out_vld, 0);
        chk("abort_feed_a", arr_a, 0);
        bus.in_vld = 1'b0;
        sb_q.delete();
        @(posedge CLK); #1;
        rst = 1'b0;
        @(negedge CLK);
        chk("post_abort_in_rdy", bus.in_rdy, 1);
        chk("post_abort_vld", bus.out_vld, 0);
        chk("post_abort_done", done, 0);
        chk("post_abort_en", arr_en, 0);
        @(posedge CLK); #1;
        load_ops(0);
        check_compute(NS);
        drain(-1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
